// File: rtl/sprite_pkg.sv
// Shared state, direction and colour definitions for the sprite engine.
package sprite_pkg;
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAW     = 3'd1,
    ST_WAIT     = 3'd2,
    ST_ERASE    = 3'd3,
    ST_MOVE     = 3'd4,
    ST_HIT_DRAW = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_RIGHT = 3'd3,
    DIR_LEFT  = 3'd4
  } dir_t;

  localparam logic [2:0] DEF_FG_COLOUR  = 3'b111;
  localparam logic [2:0] DEF_BG_COLOUR  = 3'b000;
  localparam logic [2:0] DEF_HIT_COLOUR = 3'b100;

  // Held directions resolve with priority up > down > right > left.
  function automatic dir_t pick_dir(input logic up, input logic down,
                                    input logic right, input logic left);
    if (up) begin
      return DIR_UP;
    end else if (down) begin
      return DIR_DOWN;
    end else if (right) begin
      return DIR_RIGHT;
    end else if (left) begin
      return DIR_LEFT;
    end else begin
      return DIR_NONE;
    end
  endfunction
endpackage

// File: rtl/sprite_scan.sv
// Raster-order column/row walker over the sprite footprint, column fastest.
module sprite_scan #(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic advance,
  output logic col_last,
  output logic last
);
  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;

  assign col_last = (col_r == CW'(SPRITE_W - 1));
  assign last     = col_last && (row_r == RW'(SPRITE_H - 1));

  // Step the raster position per accepted pixel, wrapping to 0 after the last one
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (clear) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (advance) begin
      if (col_last) begin
        col_r <= {CW{1'b0}};
        row_r <= last ? {RW{1'b0}} : row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end
endmodule

// File: rtl/sprite_mover.sv
// Sprite engine: paints, erases and steps one rectangular sprite on the
// framebuffer, painting a hit pattern when a step would cross the border.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4,
  parameter int STEP     = 1,
  parameter int BORDER   = 4,
  parameter int START_X  = 78,
  parameter int START_Y  = 58,
  parameter int COLOUR_W = 3,
  parameter logic [COLOUR_W-1:0] FG_COLOUR  = DEF_FG_COLOUR,
  parameter logic [COLOUR_W-1:0] BG_COLOUR  = DEF_BG_COLOUR,
  parameter logic [COLOUR_W-1:0] HIT_COLOUR = DEF_HIT_COLOUR
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                tick,
  input  logic                up,
  input  logic                down,
  input  logic                left,
  input  logic                right,
  input  logic                plot_ready,
  output logic                plot,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic [X_W-1:0]      pos_x,
  output logic [Y_W-1:0]      pos_y,
  output logic                busy,
  output logic                hit
);
  // One spare bit on each axis so a step past 0 shows up as a huge value, not a wrap.
  localparam logic [X_W:0] X_MIN  = (X_W+1)'(BORDER);
  localparam logic [X_W:0] X_MAX  = (X_W+1)'(SCREEN_W - BORDER - SPRITE_W);
  localparam logic [Y_W:0] Y_MIN  = (Y_W+1)'(BORDER);
  localparam logic [Y_W:0] Y_MAX  = (Y_W+1)'(SCREEN_H - BORDER - SPRITE_H);
  localparam logic [X_W:0] X_STEP = (X_W+1)'(STEP);
  localparam logic [Y_W:0] Y_STEP = (Y_W+1)'(STEP);

  state_t                state_r;
  dir_t                  dir_r;
  dir_t                  dir_s;
  logic [X_W-1:0]        pos_x_r;
  logic [Y_W-1:0]        pos_y_r;
  logic                  plot_r;
  logic [X_W-1:0]        x_r;
  logic [Y_W-1:0]        y_r;
  logic [COLOUR_W-1:0]   colour_r;
  logic                  busy_r;
  logic                  hit_r;
  logic [X_W:0]          mx_s;
  logic [Y_W:0]          my_s;
  logic                  legal_s;
  logic                  accept_s;
  logic                  col_last_s;
  logic                  last_s;

  assign dir_s    = pick_dir(up, down, right, left);
  assign accept_s = plot_r & plot_ready;
  assign legal_s  = (mx_s >= X_MIN) && (mx_s <= X_MAX) && (my_s >= Y_MIN) && (my_s <= Y_MAX);

  sprite_scan #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_scan (
    .clock    (clock),
    .reset    (reset),
    .clear    (state_r == ST_IDLE),
    .advance  (accept_s),
    .col_last (col_last_s),
    .last     (last_s)
  );

  // Candidate origin for the latched direction
  always_comb begin
    mx_s = {1'b0, pos_x_r};
    my_s = {1'b0, pos_y_r};
    case (dir_r)
      DIR_UP:    my_s = {1'b0, pos_y_r} - Y_STEP;
      DIR_DOWN:  my_s = {1'b0, pos_y_r} + Y_STEP;
      DIR_RIGHT: mx_s = {1'b0, pos_x_r} + X_STEP;
      DIR_LEFT:  mx_s = {1'b0, pos_x_r} - X_STEP;
      default: begin
        mx_s = {1'b0, pos_x_r};
        my_s = {1'b0, pos_y_r};
      end
    endcase
  end

  // Control FSM with registered pixel port; outputs load on the edge entering a paint state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      dir_r    <= DIR_NONE;
      pos_x_r  <= X_W'(START_X);
      pos_y_r  <= Y_W'(START_Y);
      plot_r   <= 1'b0;
      x_r      <= {X_W{1'b0}};
      y_r      <= {Y_W{1'b0}};
      colour_r <= {COLOUR_W{1'b0}};
      busy_r   <= 1'b0;
      hit_r    <= 1'b0;
    end else begin
      if (accept_s && !last_s) begin
        x_r <= col_last_s ? pos_x_r : x_r + X_W'(1);
        y_r <= col_last_s ? y_r + Y_W'(1) : y_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            pos_x_r  <= X_W'(START_X);
            pos_y_r  <= Y_W'(START_Y);
            hit_r    <= 1'b0;
            plot_r   <= 1'b1;
            x_r      <= X_W'(START_X);
            y_r      <= Y_W'(START_Y);
            colour_r <= FG_COLOUR;
            busy_r   <= 1'b1;
            state_r  <= ST_DRAW;
          end
        end
        ST_DRAW, ST_ERASE, ST_HIT_DRAW: begin
          if (accept_s && last_s) begin
            plot_r <= 1'b0;
            busy_r <= (state_r == ST_ERASE);
            state_r <= (state_r == ST_DRAW)  ? ST_WAIT :
                       (state_r == ST_ERASE) ? ST_MOVE : ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (tick && (dir_s != DIR_NONE)) begin
            dir_r    <= dir_s;
            plot_r   <= 1'b1;
            x_r      <= pos_x_r;
            y_r      <= pos_y_r;
            colour_r <= BG_COLOUR;
            busy_r   <= 1'b1;
            state_r  <= ST_ERASE;
          end
        end
        ST_MOVE: begin
          plot_r <= 1'b1;
          busy_r <= 1'b1;
          if (legal_s) begin
            pos_x_r  <= mx_s[X_W-1:0];
            pos_y_r  <= my_s[Y_W-1:0];
            x_r      <= mx_s[X_W-1:0];
            y_r      <= my_s[Y_W-1:0];
            colour_r <= FG_COLOUR;
            state_r  <= ST_DRAW;
          end else begin
            hit_r    <= 1'b1;
            x_r      <= pos_x_r;
            y_r      <= pos_y_r;
            colour_r <= HIT_COLOUR;
            state_r  <= ST_HIT_DRAW;
          end
        end
        default: begin
          plot_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign plot   = plot_r;
  assign x      = x_r;
  assign y      = y_r;
  assign colour = colour_r;
  assign pos_x  = pos_x_r;
  assign pos_y  = pos_y_r;
  assign busy   = busy_r;
  assign hit    = hit_r;
endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: default 4x4 instance plus an 8x2, step-3 instance.
module tb_sprite_mover;
  logic       clock = 1'b0;
  logic       reset, start, tick, up, down, left, right, plot_ready;
  logic       plot, busy, hit;
  logic [7:0] x, pos_x;
  logic [6:0] y, pos_y;
  logic [2:0] colour;
  logic       start2, tick2, right2;
  logic       plot2, busy2, hit2;
  logic [7:0] x2, pos_x2;
  logic [6:0] y2, pos_y2;
  logic [2:0] colour2;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clock = ~clock;

  sprite_mover dut (
    .clock(clock), .reset(reset), .start(start), .tick(tick),
    .up(up), .down(down), .left(left), .right(right), .plot_ready(plot_ready),
    .plot(plot), .x(x), .y(y), .colour(colour),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .hit(hit)
  );

  sprite_mover #(.SPRITE_W(8), .SPRITE_H(2), .STEP(3)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .tick(tick2),
    .up(1'b0), .down(1'b0), .left(1'b0), .right(right2), .plot_ready(1'b1),
    .plot(plot2), .x(x2), .y(y2), .colour(colour2),
    .pos_x(pos_x2), .pos_y(pos_y2), .busy(busy2), .hit(hit2)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] get_pix(input int which);
    if (which == 0) return {13'd0, plot, colour, x, y};
    else            return {13'd0, plot2, colour2, x2, y2};
  endfunction

  function automatic logic [31:0] exp_pix(input int c, input int xx, input int yy);
    return {13'd0, 1'b1, 3'(c), 8'(xx), 7'(yy)};
  endfunction

  task automatic check_paint(input int which, input int bx, input int by, input int w,
                             input int h, input int c, input string tag);
    for (int k = 0; k < w * h; k++) begin
      check_val(tag, get_pix(which), exp_pix(c, bx + k % w, by + k / w));
      step();
    end
  endtask

  task automatic wait_idle(input int which, input string tag);
    int n = 0;
    while (n < 200 && ((which == 0) ? busy : busy2)) begin
      step();
      n++;
    end
    check_val(tag, (which == 0) ? busy : busy2, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    reset = 1'b0; start = 1'b0; tick = 1'b0; up = 1'b0; down = 1'b0;
    left = 1'b0; right = 1'b0; plot_ready = 1'b1;
    start2 = 1'b0; tick2 = 1'b0; right2 = 1'b0;
    step(); step();
    check_val("rst_plot", plot, 32'd0);
    check_val("rst_xyc", {x, y, colour}, 32'd0);
    check_val("rst_busy_hit", {busy, hit}, 32'd0);
    check_val("rst_pos", {pos_x, pos_y}, {8'd78, 7'd58});
    reset = 1'b1;
    step();
    check_val("idle_plot", plot, 32'd0);

    // Initial paint
    start = 1'b1; step(); start = 1'b0;
    check_paint(0, 78, 58, 4, 4, 7, "draw");
    check_val("draw_end", {plot, busy}, 32'd0);

    // Step right
    right = 1'b1; tick = 1'b1; step(); tick = 1'b0; right = 1'b0;
    check_paint(0, 78, 58, 4, 4, 0, "erase");
    check_val("move_cyc", {plot, busy, pos_x}, {1'b0, 1'b1, 8'd78});
    step();
    check_paint(0, 79, 58, 4, 4, 7, "redraw");
    check_val("redraw_pos", {busy, pos_x, pos_y}, {1'b0, 8'd79, 7'd58});

    // Step down with plot_ready toggling through the redraw
    down = 1'b1; tick = 1'b1; step(); tick = 1'b0; down = 1'b0;
    check_paint(0, 79, 58, 4, 4, 0, "erase_dn");
    step();
    for (int c = 0; c < 32; c++) begin
      plot_ready = (c % 2 == 1);
      check_val("stall_px", get_pix(0), exp_pix(7, 79 + (c / 2) % 4, 59 + (c / 2) / 4));
      step();
    end
    plot_ready = 1'b1;
    check_val("stall_done", {plot, busy}, 32'd0);
    check_val("stall_pos", {pos_x, pos_y}, {8'd79, 7'd59});

    // Up+left held: up wins; extra tick and direction change mid-erase ignored
    up = 1'b1; left = 1'b1; tick = 1'b1; step(); tick = 1'b0;
    repeat (3) step();
    tick = 1'b1; down = 1'b1; step(); tick = 1'b0; down = 1'b0;
    wait_idle(0, "ul_done");
    up = 1'b0; left = 1'b0;
    check_val("ul_pos", {pos_x, pos_y}, {8'd79, 7'd58});
    seen = 1'b0;
    repeat (40) begin
      step();
      if (plot) seen = 1'b1;
    end
    check_val("tick_dropped", seen, 32'd0);

    // Walk up to the border, then bump it
    for (int i = 0; i < 54; i++) begin
      up = 1'b1; tick = 1'b1; step(); tick = 1'b0; up = 1'b0;
      wait_idle(0, "up_step");
    end
    check_val("at_border", {pos_x, pos_y}, {8'd79, 7'd4});
    up = 1'b1; tick = 1'b1; step(); tick = 1'b0; up = 1'b0;
    check_paint(0, 79, 4, 4, 4, 0, "erase_hit");
    check_val("hit_move_plot", plot, 32'd0);
    step();
    check_val("hit_flag", {hit, pos_x, pos_y}, {1'b1, 8'd79, 7'd4});
    check_paint(0, 79, 4, 4, 4, 4, "hit_px");
    check_val("hit_end", {plot, busy, hit}, {1'b0, 1'b0, 1'b1});
    up = 1'b1; tick = 1'b1; step(); step(); tick = 1'b0; up = 1'b0;
    check_val("idle_tick", {plot, pos_y}, {1'b0, 7'd4});

    // Restart, step right, reset in the middle of the redraw
    start = 1'b1; step(); start = 1'b0;
    check_val("start_clr", {hit, pos_x, pos_y}, {1'b0, 8'd78, 7'd58});
    wait_idle(0, "restart_done");
    right = 1'b1; tick = 1'b1; step(); tick = 1'b0; right = 1'b0;
    repeat (22) step();
    check_val("pre_rst", {plot, pos_x}, {1'b1, 8'd79});
    #2 reset = 1'b0;
    #1;
    check_val("rst_mid_plot", plot, 32'd0);
    check_val("rst_mid_pos", {hit, busy, pos_x, pos_y}, {1'b0, 1'b0, 8'd78, 7'd58});
    check_val("rst_mid_xyc", {x, y, colour}, 32'd0);
    step();
    reset = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      step();
      if (plot) seen = 1'b1;
    end
    check_val("rst_no_writes", seen, 32'd0);

    // 8x2 sprite, step 3
    start2 = 1'b1; step(); start2 = 1'b0;
    check_paint(1, 78, 58, 8, 2, 7, "d2_draw");
    check_val("d2_draw_end", {plot2, busy2}, 32'd0);
    right2 = 1'b1; tick2 = 1'b1; step(); tick2 = 1'b0; right2 = 1'b0;
    check_paint(1, 78, 58, 8, 2, 0, "d2_erase");
    check_val("d2_move_plot", plot2, 32'd0);
    step();
    check_paint(1, 81, 58, 8, 2, 7, "d2_redraw");
    check_val("d2_pos", {busy2, hit2, pos_x2, pos_y2}, {1'b0, 1'b0, 8'd81, 7'd58});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sprite_mover.md
# sprite_mover

Parametrised sprite engine that owns one rectangular sprite on the pixel framebuffer: it draws the sprite, erases and redraws it one step away on each rate tick while a direction is held, and paints a terminal "hit" pattern when a move would cross the play-field border. It sits between the keyboard direction decoder and rate divider on one side and the VGA adapter's pixel-write port on the other. It generalises the fixed 4x4 move-by-one game logic to any sprite size, screen size, step and border, and adds a plot handshake and border clamping.

## Interface
- SCREEN_W, 160: framebuffer width in pixels
- SCREEN_H, 120: framebuffer height in pixels
- X_W, 8: x coordinate width; must satisfy 2^X_W >= SCREEN_W
- Y_W, 7: y coordinate width; must satisfy 2^Y_W >= SCREEN_H
- SPRITE_W, 4: sprite width, 1..16
- SPRITE_H, 4: sprite height, 1..16
- STEP, 1: pixels moved per tick, >= 1
- BORDER, 4: width of the forbidden margin on every edge
- START_X, 78 / START_Y, 58: sprite origin (top-left) after start
- COLOUR_W, 3: colour width
- FG_COLOUR 3'b111, BG_COLOUR 3'b000, HIT_COLOUR 3'b100: sprite, background, hit colours
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- start  in  1  level; sampled in IDLE only
- tick  in  1  one-cycle movement enable from rate divider
- up, down, left, right  in  1  held-direction levels
- plot_ready  in  1  pixel sink accepts; tie 1 for the VGA adapter
- plot  out  1  pixel write valid
- x  out  X_W  pixel x
- y  out  Y_W  pixel y
- colour  out  COLOUR_W  pixel colour
- pos_x  out  X_W  current sprite origin x
- pos_y  out  Y_W  current sprite origin y
- busy  out  1  high in every state except IDLE and WAIT
- hit  out  1  sticky border-hit flag

## Operation
- States: IDLE, DRAW, WAIT, ERASE, MOVE, HIT_DRAW.
- IDLE: plot=0. start=1 -> load pos=START_X/START_Y, clear hit, go DRAW.
- DRAW / ERASE / HIT_DRAW: scan sprite raster-order, column fastest; emits x=pos_x+col, y=pos_y+row, colour FG/BG/HIT. Scan advances only when plot & plot_ready. After last pixel (col=SPRITE_W-1,row=SPRITE_H-1) accepted: DRAW -> WAIT, ERASE -> MOVE, HIT_DRAW -> IDLE.
- WAIT: tick=1 and any direction high -> ERASE, latching direction with priority up > down > right > left. tick with no direction: stay. tick outside WAIT is dropped, never queued.
- MOVE (one cycle): up y-=STEP, down y+=STEP, left x-=STEP, right x+=STEP. y grows downward. Legal origin: BORDER <= x <= SCREEN_W-BORDER-SPRITE_W, same for y with SCREEN_H/SPRITE_H. Compute in X_W+1 / Y_W+1 bits so underflow is detected, not wrapped. Legal -> update pos, go DRAW. Illegal -> pos unchanged, hit<=1, go HIT_DRAW.
- Direction changes during ERASE do not alter the latched move.
- start outside IDLE ignored.

## Timing
- Reset (async, immediate): state IDLE, plot=0, x=0, y=0, colour=0, busy=0, hit=0, pos_x=START_X, pos_y=START_Y, scan counters 0. Reset mid-scan aborts with no further writes.
- plot, x, y, colour registered; valid the cycle after state entry. Held stable while plot & !plot_ready.
- With plot_ready=1: a full sprite paint takes SPRITE_W*SPRITE_H cycles; tick-to-redraw-complete = 1 (ERASE entry) + N erase + 1 MOVE + N draw cycles, N=SPRITE_W*SPRITE_H.
- pos_x/pos_y change only in the MOVE cycle or on start.
- busy registered with state.

## Structure
- Package sprite_pkg: state enum, direction encoding (NONE/UP/DOWN/RIGHT/LEFT), default colour constants.
- One sub-module, sprite_scan: col/row counter with advance, clear and last-pixel outputs, parametrised on SPRITE_W/SPRITE_H. FSM, bounds arithmetic and output registers stay in sprite_mover.

## Test plan
- Defaults, reset released, start pulse -> 16 plots, colour 3'b111, (78,58)..(81,61) raster order, then busy=0.
- WAIT, right held, one tick -> 16 erase plots colour 0 at x 78..81, then 16 draws at x 79..82; pos_x=79.
- plot_ready toggled 1/0 each cycle during DRAW -> 16 accepted pixels, x/y/colour held while stalled, 32 cycles total.
- pos_y=4, up held, tick -> erase, hit=1, pos_y stays 4, 16 plots colour 3'b100, return to IDLE.
- up and left held together, tick -> pos_y decreases by STEP, pos_x unchanged; tick during ERASE ignored.
- reset asserted mid-DRAW -> plot=0 same cycle, pos=(78,58), hit=0; SPRITE_W=8,SPRITE_H=2,STEP=3 instance moves 3 px and paints 16 pixels.
